// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enabled two-port RAM and its clear sequencer.
package ram_pkg;

  typedef enum logic {RAM_CLEAR, RAM_READY} ram_clr_state_t;

  function automatic int unsigned ram_nbytes(input int unsigned width);
    return (width - 1) / 8 + 1;
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear sequencer: after reset it walks every address once, emitting a zero-write per cycle,
// then parks in RAM_READY until the next reset.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned CLEARRST = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     busy,
  output logic                     clr_we,
  output logic [$clog2(DEPTH)-1:0] clr_addr
);

  localparam int unsigned AW = $clog2(DEPTH);

  ram_clr_state_t  state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (CLEARRST != 0) ? RAM_CLEAR : RAM_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RAM_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      // Last word is written this cycle; leave CLEAR so busy spans exactly DEPTH cycles.
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_d = RAM_READY;
      end
    end
  end

  assign busy     = (state_q == RAM_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/ram2p1r1wbe_pipe.sv
// Two-port RAM (1 read, 1 byte-enabled write) with read latency 1 or 2, read-valid strobe and
// clear-on-reset. Define RAM_FWD_EN for write-first collisions; read-first otherwise.
module ram2p1r1wbe_pipe
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH    = 68,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned RDLAT    = 1,
  parameter int unsigned CLEARRST = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ce1,
  input  logic [$clog2(DEPTH)-1:0]        ra1,
  output logic [WIDTH-1:0]                rd1,
  output logic                            rv1,
  input  logic                            ce2,
  input  logic                            we2,
  input  logic [$clog2(DEPTH)-1:0]        wa2,
  input  logic [WIDTH-1:0]                wd2,
  input  logic [ram_nbytes(WIDTH)-1:0]    bwe2,
  output logic                            busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             rd_acc, wr_acc;
  logic [WIDTH-1:0] wmask;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata, mem_wmask;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] mem_q [DEPTH];

  ram_clear_ctrl #(
    .DEPTH   (DEPTH),
    .CLEARRST(CLEARRST)
  ) u_clear (
    .clk     (clk),
    .reset   (reset),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  assign rd_acc = ce1 & ~busy;
  assign wr_acc = ce2 & we2 & ~busy;

  always_comb begin
    wmask = '0;
    for (int b = 0; b < int'(WIDTH); b++) begin
      wmask[b] = bwe2[b / 8];
    end
  end

  // Clear owns the write port while it runs.
  always_comb begin
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
      mem_wmask = '1;
    end else begin
      mem_we    = wr_acc;
      mem_waddr = wa2;
      mem_wdata = wd2;
      mem_wmask = wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= (mem_q[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end
  end

`ifdef RAM_FWD_EN
  assign rdata = (wr_acc && (wa2 == ra1)) ? ((mem_q[ra1] & ~wmask) | (wd2 & wmask))
                                          : mem_q[ra1];
`else
  assign rdata = mem_q[ra1];
`endif

  // Capture stage samples the array at the accepting edge, fixing collision semantics there.
  logic             cap_v_q;
  logic [WIDTH-1:0] cap_d_q;
  logic             out_v;
  logic [WIDTH-1:0] out_d;
  logic             rv1_q;
  logic [WIDTH-1:0] rd1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_v_q <= 1'b0;
      cap_d_q <= '0;
    end else begin
      cap_v_q <= rd_acc;
      if (rd_acc) begin
        cap_d_q <= rdata;
      end
    end
  end

  if (RDLAT == 2) begin : g_lat2
    logic             s2_v_q;
    logic [WIDTH-1:0] s2_d_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        s2_v_q <= 1'b0;
        s2_d_q <= '0;
      end else begin
        s2_v_q <= cap_v_q;
        s2_d_q <= cap_d_q;
      end
    end

    assign out_v = s2_v_q;
    assign out_d = s2_d_q;
  end else begin : g_lat1
    if (RDLAT != 1) begin : g_bad_rdlat
      $error("ram2p1r1wbe_pipe: RDLAT must be 1 or 2");
    end
    assign out_v = cap_v_q;
    assign out_d = cap_d_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rv1_q <= 1'b0;
      rd1_q <= '0;
    end else begin
      rv1_q <= out_v;
      if (out_v) begin
        rd1_q <= out_d;
      end
    end
  end

  assign rv1 = rv1_q;
  assign rd1 = rd1_q;

endmodule

// File: tb/tb_ram2p1r1wbe_pipe.sv
// Randomised bench for ram2p1r1wbe_pipe: two instances (68x1024 lat 1, 2x64 lat 2) against a
// behavioural array/queue model, plus literal directed checks.
module tb_ram2p1r1wbe_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        ce1_a = 0, ce2_a = 0, we2_a = 0;
  logic [9:0]  ra1_a = '0, wa2_a = '0;
  logic [67:0] wd2_a = '0, rd1_a;
  logic [8:0]  bwe2_a = '0;
  logic        rv1_a, busy_a;

  logic        ce1_b = 0, ce2_b = 0, we2_b = 0;
  logic [5:0]  ra1_b = '0, wa2_b = '0;
  logic [1:0]  wd2_b = '0, rd1_b;
  logic [0:0]  bwe2_b = '0;
  logic        rv1_b, busy_b;

  ram2p1r1wbe_pipe #(.WIDTH(68), .DEPTH(1024), .RDLAT(1), .CLEARRST(1)) u_a (
    .clk(clk), .reset(reset), .ce1(ce1_a), .ra1(ra1_a), .rd1(rd1_a), .rv1(rv1_a),
    .ce2(ce2_a), .we2(we2_a), .wa2(wa2_a), .wd2(wd2_a), .bwe2(bwe2_a), .busy(busy_a)
  );

  ram2p1r1wbe_pipe #(.WIDTH(2), .DEPTH(64), .RDLAT(2), .CLEARRST(1)) u_b (
    .clk(clk), .reset(reset), .ce1(ce1_b), .ra1(ra1_b), .rd1(rd1_b), .rv1(rv1_b),
    .ce2(ce2_b), .we2(we2_b), .wa2(wa2_b), .wd2(wd2_b), .bwe2(bwe2_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string nm, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: per-instance word array, countdown of clear cycles, and a delay queue of RDLAT
  // slots holding {valid, data} sampled at the accepting edge.
  typedef struct packed {
    logic        v;
    logic [67:0] d;
  } ent_t;

  int          dep [2] = '{1024, 64};
  int          lat [2] = '{1, 2};
  logic [67:0] wm  [2] = '{{68{1'b1}}, 68'h3};
  logic [67:0] mem [2][1024];
  ent_t        q   [2][$];
  int          left[2];
  logic [67:0] erd [2];
  logic        erv [2];
  logic        m_init = 1'b0;

  function automatic logic [67:0] merge(input logic [67:0] o, input logic [67:0] n,
                                        input logic [8:0] be);
    logic [67:0] r;
    r = o;
    for (int b = 0; b < 68; b++) if (be[b / 8]) r[b] = n[b];
    return r;
  endfunction

  task automatic step(input int k, input logic c1, input logic c2, input logic w2,
                      input int ra, input int wa, input logic [67:0] wd, input logic [8:0] be);
    ent_t        e;
    ent_t        ne;
    logic [67:0] rv;
    if (reset) begin
      for (int i = 0; i < dep[k]; i++) mem[k][i] = '0;
      left[k] = dep[k];
      q[k].delete();
      for (int i = 0; i < lat[k]; i++) q[k].push_back('0);
      erd[k] = '0;
      erv[k] = 1'b0;
      return;
    end
    e = q[k].pop_front();
    erv[k] = e.v;
    if (e.v) erd[k] = e.d;
    if (left[k] > 0) begin
      left[k]--;
      q[k].push_back('0);
      return;
    end
    rv = mem[k][ra];
`ifdef RAM_FWD_EN
    if (c1 && c2 && w2 && ra == wa) rv = merge(rv, wd, be) & wm[k];
`endif
    ne.v = c1;
    ne.d = rv;
    q[k].push_back(ne);
    if (c2 && w2) mem[k][wa] = merge(mem[k][wa], wd, be) & wm[k];
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (reset) m_init = 1'b1;
      if (m_init) begin
        step(0, ce1_a, ce2_a, we2_a, int'(ra1_a), int'(wa2_a), wd2_a, bwe2_a);
        step(1, ce1_b, ce2_b, we2_b, int'(ra1_b), int'(wa2_b), {66'b0, wd2_b}, {8'b0, bwe2_b});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        cmp("busy_a", {67'b0, busy_a}, {67'b0, left[0] > 0});
        cmp("rv1_a", {67'b0, rv1_a}, {67'b0, erv[0]});
        cmp("rd1_a", rd1_a, erd[0]);
        cmp("busy_b", {67'b0, busy_b}, {67'b0, left[1] > 0});
        cmp("rv1_b", {67'b0, rv1_b}, {67'b0, erv[1]});
        cmp("rd1_b", {66'b0, rd1_b}, erd[1]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce1_a = 0; ce2_a = 0; we2_a = 0;
    ce1_b = 0; ce2_b = 0; we2_b = 0;
  endtask

  // Drive junk while busy; none of it may reach the array or the read pipe.
  task automatic count_busy(output int n);
    n = 0;
    while (busy_a && n < 2000) begin
      ce1_a = 1'($urandom); ce2_a = 1'($urandom); we2_a = 1'($urandom);
      ra1_a = 10'($urandom); wa2_a = 10'($urandom); wd2_a = '1; bwe2_a = '1;
      ce1_b = 1'($urandom); ce2_b = 1'($urandom); we2_b = 1'($urandom);
      ra1_b = 6'($urandom); wa2_b = 6'($urandom); wd2_b = '1; bwe2_b = '1;
      tick();
      n++;
    end
    idle();
  endtask

  task automatic wr_a(input int a, input logic [67:0] d, input logic [8:0] be);
    ce2_a = 1; we2_a = 1; wa2_a = 10'(a); wd2_a = d; bwe2_a = be;
  endtask

  task automatic wr_b(input int a, input logic [1:0] d, input logic be);
    ce2_b = 1; we2_b = 1; wa2_b = 6'(a); wd2_b = d; bwe2_b = be;
  endtask

  int          n;
  int          nrv;
  int          nz;
  logic [67:0] va;

  initial begin
    // T2: reset 500 cycles into the clear restarts it; T6 junk driven throughout.
    reset = 1; tick(); tick(); reset = 0;
    for (int i = 0; i < 500; i++) begin
      ce1_a = 1'($urandom); ce2_a = 1; we2_a = 1; wa2_a = 10'($urandom); wd2_a = '1;
      bwe2_a = '1; tick();
    end
    idle();
    reset = 1; tick(); reset = 0;
    count_busy(n);
    cmp("t2_busy_cycles", 68'(n), 68'd1024);

    // T1: full reset then full clear.
    reset = 1; tick(); tick(); reset = 0;
    count_busy(n);
    cmp("t1_busy_cycles", 68'(n), 68'd1024);

    nrv = 0; nz = 0;
    for (int i = 0; i < 1027; i++) begin
      ce1_a = (i < 1024); ra1_a = 10'(i);
      ce1_b = (i < 64);   ra1_b = 6'(i);
      tick();
      if (rv1_a) begin
        nrv++;
        if (rd1_a != '0) nz++;
      end
    end
    idle();
    cmp("t1_rv_count", 68'(nrv), 68'd1024);
    cmp("t1_nonzero_words", 68'(nz), 68'd0);

    // T3: byte-lane merge on both widths.
    wr_a(5, '1, '1); wr_b(5, 2'b11, 1'b1); tick();
    wr_a(5, '0, 9'h001); wr_b(5, 2'b00, 1'b0); tick();
    idle(); ce1_a = 1; ra1_a = 5; ce1_b = 1; ra1_b = 5; tick();
    idle(); tick();
    cmp("t3_rd_a", rd1_a, 68'hF_FFFF_FFFF_FFFF_FF00);
    cmp("t3_model_a", erd[0], 68'hF_FFFF_FFFF_FFFF_FF00);
    cmp("t3_rv_a", {67'b0, rv1_a}, 68'd1);
    tick();
    cmp("t3_rd_b", {66'b0, rd1_b}, 68'h3);
    cmp("t3_rv_b", {67'b0, rv1_b}, 68'd1);

    // T4: three back-to-back reads; lat 1 valid after edges t+1..t+3, lat 2 after t+2..t+4.
    for (int i = 1; i <= 3; i++) begin
      wr_a(i, 68'(i) * 68'h1_0000_0001_0000_0001, '1); wr_b(i, 2'(i), 1'b1); tick();
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      ce1_a = (i < 3); ra1_a = 10'(i + 1);
      ce1_b = (i < 3); ra1_b = 6'(i + 1);
      tick();
      cmp("t4_rv_a", {67'b0, rv1_a}, {67'b0, (i >= 1 && i <= 3)});
      cmp("t4_rv_b", {67'b0, rv1_b}, {67'b0, (i >= 2 && i <= 4)});
      if (i >= 1 && i <= 3) cmp("t4_rd_a", rd1_a, 68'(i) * 68'h1_0000_0001_0000_0001);
      if (i >= 2 && i <= 4) cmp("t4_rd_b", {66'b0, rd1_b}, 68'(i - 1));
    end
    idle();

    // T5: same-edge read and partial write of word 7.
    wr_a(7, '0, '1); tick();
    idle(); ce1_a = 1; ra1_a = 7; wr_a(7, '1, 9'h003); tick();
    idle(); tick();
`ifdef RAM_FWD_EN
    va = 68'h0_0000_0000_0000_FFFF;
`else
    va = 68'h0;
`endif
    cmp("t5_collide_rd_a", rd1_a, va);
    ce1_a = 1; ra1_a = 7; tick();
    idle(); tick();
    cmp("t5_reread_rd_a", rd1_a, 68'hFFFF);

    // Random traffic on a small address window to provoke collisions; one reset mid-way.
    for (int c = 0; c < 4000; c++) begin
      ce1_a = 1'($urandom); ce2_a = 1'($urandom); we2_a = 1'($urandom);
      ra1_a = 10'($urandom_range(0, 7)); wa2_a = 10'($urandom_range(0, 7));
      wd2_a = {4'($urandom), $urandom, $urandom}; bwe2_a = 9'($urandom);
      ce1_b = 1'($urandom); ce2_b = 1'($urandom); we2_b = 1'($urandom);
      ra1_b = 6'($urandom_range(0, 7)); wa2_b = 6'($urandom_range(0, 7));
      wd2_b = 2'($urandom); bwe2_b = 1'($urandom);
      reset = (c == 2000);
      tick();
    end
    reset = 0;
    idle();
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
